// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding at capture time, load-use stall
// with bubble insertion, branch flush and a saturating stall counter.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_op,
    input  logic              ex_fwd_we,
    input  logic [REG_AW-1:0] ex_fwd_rd,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [DATA_W-1:0] wb_fwd_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              haz;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Register 0 is hardwired to zero; EX result is younger than MEM/WB so it wins.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] idx,
                                              input logic [DATA_W-1:0] rf);
        logic [DATA_W-1:0] val;
        if (idx == '0) begin
            val = '0;
        end else if (ex_fwd_we && (ex_fwd_rd == idx)) begin
            val = ex_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_rd == idx)) begin
            val = wb_fwd_data;
        end else begin
            val = rf;
        end
        return val;
    endfunction

    always_comb begin
        haz   = ex_valid && ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
        stall = id_valid && haz && !flush;
        fwd_a = fwd(id_rs, id_rd1);
        fwd_b = fwd(id_rt, id_rd2);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
            stall_cnt     <= '0;
        end else if (flush || stall) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
            // stall is already masked by flush, so a flushed hazard is not counted
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CntOne;
            end
        end else begin
            ex_valid      <= id_valid;
            ex_rd         <= id_valid ? id_rd : '0;
            ex_reg_write  <= id_valid && id_reg_write;
            ex_mem_read   <= id_valid && id_mem_read;
            ex_mem_write  <= id_valid && id_mem_write;
            ex_alu_src    <= id_valid && id_alu_src;
            ex_alu_op     <= id_valid ? id_alu_op : 4'd0;
            ex_op_a       <= fwd_a;
            ex_op_b       <= id_alu_src ? id_imm : fwd_b;
            ex_store_data <= fwd_b;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, load-use stall/bubble,
// flush precedence, register-0 handling, immediate select and counter saturation.
module tb_id_ex_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic [3:0]  id_alu_op;
    logic        ex_fwd_we, wb_fwd_we, flush;
    logic [4:0]  ex_fwd_rd, wb_fwd_rd;
    logic [31:0] ex_fwd_data, wb_fwd_data;

    logic        stall, ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_op_a, ex_op_b, ex_store_data;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic [15:0] stall_cnt;

    logic        s_stall, s_ex_valid;
    logic [4:0]  s_ex_rd;
    logic [31:0] s_ex_op_a, s_ex_op_b, s_ex_store_data;
    logic        s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_alu_src;
    logic [3:0]  s_ex_alu_op;
    logic [3:0]  s_stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    id_ex_stage dut (
        .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .ex_fwd_we(ex_fwd_we), .ex_fwd_rd(ex_fwd_rd),
        .ex_fwd_data(ex_fwd_data), .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd),
        .wb_fwd_data(wb_fwd_data), .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy on the same stimulus so saturation is reached in a short run.
    id_ex_stage #(.CNT_W(4)) dut_sat (
        .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .ex_fwd_we(ex_fwd_we), .ex_fwd_rd(ex_fwd_rd),
        .ex_fwd_data(ex_fwd_data), .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd),
        .wb_fwd_data(wb_fwd_data), .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid),
        .ex_rd(s_ex_rd), .ex_op_a(s_ex_op_a), .ex_op_b(s_ex_op_b),
        .ex_store_data(s_ex_store_data), .ex_reg_write(s_ex_reg_write),
        .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write),
        .ex_alu_src(s_ex_alu_src), .ex_alu_op(s_ex_alu_op), .stall_cnt(s_stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_src = 0; id_alu_op = 0;
        ex_fwd_we = 0; ex_fwd_rd = 0; ex_fwd_data = 0;
        wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
        flush = 0;
    endtask

    task automatic drive_load5();
        clear_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5;
        id_rs = 1; id_uses_rs = 1; id_rd1 = 32'h40; id_alu_src = 1; id_imm = 32'h8;
    endtask

    task automatic drive_reader5(input bit via_rt);
        clear_inputs();
        id_valid = 1; id_reg_write = 1; id_rd = 6; id_alu_op = 4'h2;
        id_rd1 = 32'h999; id_rd2 = 32'h888;
        if (via_rt) begin
            id_rt = 5; id_uses_rt = 1;
        end else begin
            id_rs = 5; id_uses_rs = 1;
        end
    endtask

    initial begin
        Reset = 1;
        id_valid = 1'($urandom); id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
        id_mem_write = 1'($urandom); id_alu_src = 1'($urandom); id_alu_op = 4'($urandom);
        ex_fwd_we = 1'($urandom); ex_fwd_rd = 5'($urandom); ex_fwd_data = $urandom;
        wb_fwd_we = 1'($urandom); wb_fwd_rd = 5'($urandom); wb_fwd_data = $urandom;
        flush = 1'($urandom);
        step();
        step();
        check_eq("rst_ex_valid", 32'(ex_valid), 0);
        check_eq("rst_ex_rd", 32'(ex_rd), 0);
        check_eq("rst_op_a", ex_op_a, 0);
        check_eq("rst_op_b", ex_op_b, 0);
        check_eq("rst_store", ex_store_data, 0);
        check_eq("rst_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src}), 0);
        check_eq("rst_alu_op", 32'(ex_alu_op), 0);
        check_eq("rst_stall", 32'(stall), 0);
        check_eq("rst_cnt", 32'(stall_cnt), 0);

        // Forwarding priority: EX, then WB, then register file
        clear_inputs();
        Reset = 0;
        id_valid = 1; id_rs = 3; id_uses_rs = 1; id_rd1 = 32'h11; id_rd = 7; id_alu_op = 4'h5;
        ex_fwd_we = 1; ex_fwd_rd = 3; ex_fwd_data = 32'hAA;
        wb_fwd_we = 1; wb_fwd_rd = 3; wb_fwd_data = 32'hBB;
        step();
        check_eq("fwd_ex", ex_op_a, 32'hAA);
        check_eq("fwd_valid", 32'(ex_valid), 1);
        check_eq("fwd_alu_op", 32'(ex_alu_op), 5);
        ex_fwd_we = 0;
        step();
        check_eq("fwd_wb", ex_op_a, 32'hBB);
        wb_fwd_we = 0;
        step();
        check_eq("fwd_rf", ex_op_a, 32'h11);

        // Load-use: one bubble, then the reader picks up the load data from WB
        drive_load5();
        step();
        check_eq("lw_mem_read", 32'(ex_mem_read), 1);
        check_eq("lw_rd", 32'(ex_rd), 5);
        drive_reader5(0);
        #1;
        check_eq("lu_stall", 32'(stall), 1);
        step();
        check_eq("lu_bubble_valid", 32'(ex_valid), 0);
        check_eq("lu_bubble_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 0);
        check_eq("lu_cnt", 32'(stall_cnt), 1);
        check_eq("lu_stall_drop", 32'(stall), 0);
        wb_fwd_we = 1; wb_fwd_rd = 5; wb_fwd_data = 32'h1234;
        step();
        check_eq("lu_capture_valid", 32'(ex_valid), 1);
        check_eq("lu_capture_op_a", ex_op_a, 32'h1234);
        check_eq("lu_capture_rd", 32'(ex_rd), 6);

        // Flush beats stall
        drive_load5();
        step();
        drive_reader5(1);
        flush = 1;
        #1;
        check_eq("fl_stall", 32'(stall), 0);
        step();
        check_eq("fl_valid", 32'(ex_valid), 0);
        check_eq("fl_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 0);
        check_eq("fl_cnt", 32'(stall_cnt), 1);

        // Register 0 never forwards and never stalls
        clear_inputs();
        id_valid = 1; id_rs = 0; id_uses_rs = 1; id_rd1 = 32'h55;
        ex_fwd_we = 1; ex_fwd_rd = 0; ex_fwd_data = 32'hFF;
        step();
        check_eq("r0_op_a", ex_op_a, 0);
        clear_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 0;
        step();
        clear_inputs();
        id_valid = 1; id_rs = 0; id_uses_rs = 1; id_rt = 0; id_uses_rt = 1; id_rd = 9;
        #1;
        check_eq("r0_no_stall", 32'(stall), 0);
        step();
        check_eq("r0_valid", 32'(ex_valid), 1);

        // Immediate select versus forwarded store data
        clear_inputs();
        id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFF0; id_mem_write = 1;
        id_rt = 2; id_uses_rt = 1; id_rd2 = 32'h3;
        ex_fwd_we = 1; ex_fwd_rd = 2; ex_fwd_data = 32'h77;
        step();
        check_eq("imm_op_b", ex_op_b, 32'hFFFF_FFF0);
        check_eq("imm_store", ex_store_data, 32'h77);
        check_eq("imm_ctrl", 32'({ex_mem_write, ex_alu_src}), 32'h3);
        id_alu_src = 0;
        step();
        check_eq("reg_op_b", ex_op_b, 32'h77);

        // Repeated load-use pairs: wide counter counts exactly, narrow one saturates
        for (int i = 0; i < 20; i++) begin
            drive_load5();
            step();
            drive_reader5(i[0]);
            step();
            if (i == 13) check_eq("sat_cnt_pre", 32'(s_stall_cnt), 4'hF);
        end
        check_eq("cnt_exact", 32'(stall_cnt), 21);
        check_eq("cnt_sat", 32'(s_stall_cnt), 4'hF);

        // Reset while stalled
        drive_load5();
        step();
        drive_reader5(0);
        #1;
        check_eq("mid_stall", 32'(stall), 1);
        Reset = 1;
        step();
        check_eq("mid_rst_stall", 32'(stall), 0);
        check_eq("mid_rst_cnt", 32'(stall_cnt), 0);
        check_eq("mid_rst_valid", 32'(ex_valid), 0);
        Reset = 0;
        clear_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
